// File: rtl/uart_tx_if.sv
// UART transmitter bus: request/payload/config from the system side,
// serial line and busy flag back from the transmitter.
interface uart_tx_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      DATA_VALID;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic                      TX_OUT;
    logic                      BUSY;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, prescale,
        input  TX_OUT, BUSY
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, prescale,
        output TX_OUT, BUSY
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmit serializer: start bit, LSB-first data, optional parity,
// one stop bit, each bit held for a programmable number of clocks.
// Everything a frame needs is captured on accept, so input changes while
// busy cannot disturb the frame on the line.
module uart_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input logic      CLK,
    input logic      RST,
    uart_tx_if.slave bus
);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d,
                                         input logic odd);
        return (^d) ^ odd;
    endfunction

    state_t                    state_r, state_s;
    logic [PRESCALE_WIDTH-1:0] cnt_r, cnt_s;
    logic [PRESCALE_WIDTH-1:0] last_cnt_r, last_cnt_s;   // P-1, with P=0 treated as 1
    logic [IDX_W-1:0]          idx_r, idx_s;
    logic [DATA_WIDTH-1:0]     data_r, data_s;
    logic                      par_en_r, par_en_s;
    logic                      par_bit_r, par_bit_s;
    logic                      tx_out_r, tx_out_s;
    logic                      busy_r, busy_s;
    logic                      bit_done_s;

    // Next-state, counters and next registered output values.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        last_cnt_s = last_cnt_r;
        idx_s      = idx_r;
        data_s     = data_r;
        par_en_s   = par_en_r;
        par_bit_s  = par_bit_r;
        bit_done_s = (cnt_r == last_cnt_r);

        case (state_r)
            IDLE: begin
                if (bus.DATA_VALID) begin
                    data_s    = bus.P_DATA;
                    par_en_s  = bus.PAR_EN;
                    par_bit_s = calc_parity(bus.P_DATA, bus.PAR_TYP);
                    if (bus.prescale == {PRESCALE_WIDTH{1'b0}}) begin
                        last_cnt_s = {PRESCALE_WIDTH{1'b0}};
                    end else begin
                        last_cnt_s = bus.prescale - PRESCALE_WIDTH'(1);
                    end
                    cnt_s   = {PRESCALE_WIDTH{1'b0}};
                    idx_s   = {IDX_W{1'b0}};
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START, DATA, PARITY, STOP: begin
                if (!bit_done_s) begin
                    cnt_s = cnt_r + PRESCALE_WIDTH'(1);
                end else begin
                    cnt_s = {PRESCALE_WIDTH{1'b0}};
                    case (state_r)
                        START: begin
                            idx_s   = {IDX_W{1'b0}};
                            state_s = DATA;
                        end
                        DATA: begin
                            if (idx_r != LAST_IDX) begin
                                idx_s = idx_r + IDX_W'(1);
                            end else if (par_en_r) begin
                                state_s = PARITY;
                            end else begin
                                state_s = STOP;
                            end
                        end
                        PARITY:  state_s = STOP;
                        STOP:    state_s = IDLE;
                        default: state_s = IDLE;
                    endcase
                end
            end
            default: state_s = IDLE;
        endcase

        case (state_s)
            IDLE:    begin tx_out_s = 1'b1;          busy_s = 1'b0; end
            START:   begin tx_out_s = 1'b0;          busy_s = 1'b1; end
            DATA:    begin tx_out_s = data_s[idx_s]; busy_s = 1'b1; end
            PARITY:  begin tx_out_s = par_bit_s;     busy_s = 1'b1; end
            STOP:    begin tx_out_s = 1'b1;          busy_s = 1'b1; end
            default: begin tx_out_s = 1'b1;          busy_s = 1'b0; end
        endcase
    end

    // State, counters, latched frame and registered line outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= IDLE;
            cnt_r      <= {PRESCALE_WIDTH{1'b0}};
            last_cnt_r <= {PRESCALE_WIDTH{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
            data_r     <= {DATA_WIDTH{1'b0}};
            par_en_r   <= 1'b0;
            par_bit_r  <= 1'b0;
            tx_out_r   <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            last_cnt_r <= last_cnt_s;
            idx_r      <= idx_s;
            data_r     <= data_s;
            par_en_r   <= par_en_s;
            par_bit_r  <= par_bit_s;
            tx_out_r   <= tx_out_s;
            busy_r     <= busy_s;
        end
    end

    assign bus.TX_OUT = tx_out_r;
    assign bus.BUSY   = busy_r;
endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: a queue-of-line-levels reference model checked on
// every cycle, directed frames pinned to hand-computed values, random churn.
module tb_uart_tx;
    localparam int DW = 8;
    localparam int PW = 6;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    uart_tx_if #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) bus ();

    uart_tx #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   model_on = 1'b0;
    logic model_q[$];   // expected line level for each upcoming cycle of a frame
    logic cap[$];       // captured line levels of the last measured frame
    int   m_start, m_end;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame = P cycles each of: 0, data LSB first, optional parity, 1.
    task automatic build_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                               input logic [PW-1:0] p);
        int pp;
        pp = (p == 0) ? 1 : int'(p);
        for (int k = 0; k < pp; k++) model_q.push_back(1'b0);
        for (int i = 0; i < DW; i++)
            for (int k = 0; k < pp; k++) model_q.push_back(d[i]);
        if (pe) begin
            for (int k = 0; k < pp; k++) model_q.push_back((^d) ^ pt);
        end
        for (int k = 0; k < pp; k++) model_q.push_back(1'b1);
    endtask

    // Reference model: one queue entry consumed per clock; accept only when empty.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (RST) model_q.delete();
        else if (model_q.size() == 0) begin
            if (bus.DATA_VALID === 1'b1)
                build_frame(bus.P_DATA, bus.PAR_EN, bus.PAR_TYP, bus.prescale);
        end else void'(model_q.pop_front());
    end

    // Cycle-by-cycle comparison of the DUT against the model.
    always @(negedge CLK) begin
        if (model_on) begin
            check("tx_out", 32'(bus.TX_OUT), (model_q.size() == 0) ? 32'd1 : 32'(model_q[0]));
            check("busy", 32'(bus.BUSY), (model_q.size() != 0) ? 32'd1 : 32'd0);
        end
    end

    // Records line levels from BUSY rise to BUSY fall, with bounded waits.
    task automatic measure(input string name);
        int guard;
        guard = 0;
        cap.delete();
        @(negedge CLK);
        while (bus.BUSY !== 1'b1 && guard < 3000) begin @(negedge CLK); guard++; end
        if (guard >= 3000) begin check({name, "_start_timeout"}, 32'd0, 32'd1); return; end
        m_start = cyc;
        while (bus.BUSY === 1'b1 && guard < 6000) begin
            cap.push_back(bus.TX_OUT);
            @(negedge CLK);
            guard++;
        end
        if (guard >= 6000) check({name, "_end_timeout"}, 32'd0, 32'd1);
        m_end = cyc;
    endtask

    function automatic logic [7:0] decode(input int p);
        logic [7:0] d;
        int pp;
        pp = (p == 0) ? 1 : p;
        for (int i = 0; i < 8; i++)
            d[i] = ((i + 1) * pp < cap.size()) ? cap[(i + 1) * pp] : 1'bx;
        return d;
    endfunction

    // Called just after a rising edge: presents one request for one cycle.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [PW-1:0] p);
        bus.P_DATA = d; bus.PAR_EN = pe; bus.PAR_TYP = pt; bus.prescale = p;
        bus.DATA_VALID = 1'b1;
        @(posedge CLK); #1;
        bus.DATA_VALID = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [9:0] v;
        int   hold_bad, extra, end1;

        bus.DATA_VALID = 1'b1; bus.P_DATA = 8'hA5; bus.PAR_EN = 1'b0;
        bus.PAR_TYP = 1'b0; bus.prescale = 6'd1;
        @(posedge CLK); #1;
        model_on = 1'b1;

        // Reset held with DATA_VALID high: line idle, not busy.
        repeat (3) begin
            @(negedge CLK);
            check("rst_tx", 32'(bus.TX_OUT), 32'd1);
            check("rst_busy", 32'(bus.BUSY), 32'd0);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;           // accept of 0xA5, P=1
        bus.DATA_VALID = 1'b0;
        measure("a5");
        for (int i = 0; i < 10; i++) v[i] = (i < cap.size()) ? cap[i] : 1'bx;
        check("a5_seq", 32'(v), 32'(10'b1101001010));
        check("a5_len", m_end - m_start, 32'd10);

        // Prescale 0 behaves as 1.
        gap(3);
        send(8'hA5, 1'b0, 1'b0, 6'd0);
        measure("p0");
        for (int i = 0; i < 10; i++) v[i] = (i < cap.size()) ? cap[i] : 1'bx;
        check("p0_seq", 32'(v), 32'(10'b1101001010));
        check("p0_len", m_end - m_start, 32'd10);

        // Even then odd parity on 0x03 at 8 cycles per bit.
        for (int t = 0; t < 2; t++) begin
            gap(3);
            send(8'h03, 1'b1, 1'(t), 6'd8);
            measure("par");
            check("par_len", m_end - m_start, 32'd88);
            check("par_data", 32'(decode(8)), 32'h03);
            hold_bad = 0;
            for (int k = 72; k < 80; k++)
                if (k >= cap.size() || cap[k] !== 1'(t)) hold_bad++;
            check("par_bit_hold", hold_bad, 32'd0);
        end

        // Mid-frame request and prescale change must not affect the frame.
        gap(3);
        send(8'h3C, 1'b0, 1'b0, 6'd4);
        fork
            measure("mid");
            begin
                gap(14);
                bus.DATA_VALID = 1'b1; bus.P_DATA = 8'hFF; bus.prescale = 6'd16; bus.PAR_EN = 1'b1;
                gap(1);
                bus.DATA_VALID = 1'b0;
            end
        join
        check("mid_len", m_end - m_start, 32'd40);
        check("mid_data", 32'(decode(4)), 32'h3C);
        extra = 0;
        repeat (30) begin @(negedge CLK); if (bus.BUSY !== 1'b0) extra++; end
        check("mid_dropped", extra, 32'd0);

        // Back-to-back with DATA_VALID held: exactly one idle cycle between frames.
        gap(1);
        bus.PAR_EN = 1'b0; bus.prescale = 6'd2; bus.P_DATA = 8'h55;
        bus.DATA_VALID = 1'b1;
        gap(1);
        bus.P_DATA = 8'h0F;
        measure("b2b1");
        check("b2b1_len", m_end - m_start, 32'd20);
        check("b2b1_data", 32'(decode(2)), 32'h55);
        end1 = m_end;
        gap(1);
        bus.DATA_VALID = 1'b0;
        measure("b2b2");
        check("b2b_idle", m_start - end1, 32'd1);
        check("b2b2_len", m_end - m_start, 32'd20);
        check("b2b2_data", 32'(decode(2)), 32'h0F);

        // Reset during data bit 3 (a zero bit) aborts the frame at once.
        gap(3);
        send(8'hC3, 1'b0, 1'b0, 6'd8);
        gap(33);
        RST = 1'b1;
        gap(1);
        RST = 1'b0;
        @(negedge CLK);
        check("rst_mid_tx", 32'(bus.TX_OUT), 32'd1);
        check("rst_mid_busy", 32'(bus.BUSY), 32'd0);
        gap(2);
        send(8'h96, 1'b1, 1'b1, 6'd3);
        measure("post_rst");
        check("post_rst_len", m_end - m_start, 32'd33);
        check("post_rst_data", 32'(decode(3)), 32'h96);

        // Random churn on every input, occasional reset; model checks each cycle.
        gap(1);
        for (int n = 0; n < 4000; n++) begin
            bus.DATA_VALID = ($urandom_range(0, 7) == 0);
            bus.P_DATA     = 8'($urandom);
            bus.PAR_EN     = 1'($urandom);
            bus.PAR_TYP    = 1'($urandom);
            bus.prescale   = 6'($urandom_range(0, 5));
            RST            = ($urandom_range(0, 399) == 0);
            gap(1);
        end
        RST = 1'b0;
        bus.DATA_VALID = 1'b0;
        gap(150);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmit serializer, the transmit-direction counterpart of the receive path's start/data/parity/stop sampling. It accepts a parallel byte with a one-cycle valid strobe, frames it as start bit, LSB-first data, optional parity and one stop bit, and holds each bit on the line for a programmable number of clock cycles (prescale). It sits between the system-side register/FIFO logic and the serial TX pin.

## Interface
- DATA_WIDTH, 8, payload bits per frame
- PRESCALE_WIDTH, 6, width of prescale input
- CLK  input  1  system clock; all logic on rising edge
- RST  input  1  reset, synchronous, active-high
- P_DATA  input  DATA_WIDTH  parallel payload, sampled on accept
- DATA_VALID  input  1  request strobe; accepted only when BUSY=0
- PAR_EN  input  1  1 = insert parity bit after data; sampled on accept
- PAR_TYP  input  1  0 = even, 1 = odd parity; sampled on accept
- prescale  input  PRESCALE_WIDTH  clock cycles per bit (P); sampled on accept; 0 treated as 1
- TX_OUT  output  1  serial line, idle high
- BUSY  output  1  high while a frame is on the line

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, BUSY=0. Accept when DATA_VALID=1 → latch P_DATA, PAR_EN, PAR_TYP, P; compute parity over latched data (even: XOR of bits; odd: inverted XOR); go to START.
- START: TX_OUT=0 for P cycles → DATA.
- DATA: bit index 0..DATA_WIDTH-1, LSB first, each held P cycles; after last bit → PARITY if latched PAR_EN else STOP.
- PARITY: TX_OUT=parity bit for P cycles → STOP.
- STOP: TX_OUT=1 for P cycles → IDLE.
- Per-bit cycle counter counts 0..P-1; wraps to 0 and advances bit/state on P-1. Bit index counter width ceil(log2(DATA_WIDTH)).
- DATA_VALID while BUSY=1 is ignored (no queuing, no effect on current frame); changes to P_DATA/PAR_EN/PAR_TYP/prescale mid-frame have no effect.
- TX_OUT and BUSY are registered outputs (no combinational path from inputs).
- RST: next edge forces state IDLE, counters 0, TX_OUT=1, BUSY=0; dominates simultaneous DATA_VALID; reset mid-frame aborts frame immediately (line returns high, no stop-bit completion).

## Timing
- Reset values: TX_OUT=1, BUSY=0.
- Accept at edge N (DATA_VALID=1, BUSY=0) → edge N+1: TX_OUT=0, BUSY=1.
- Data bit i driven from N+1+(i+1)·P for P cycles.
- Parity (if enabled) from N+1+(DATA_WIDTH+1)·P.
- Stop bit from N+1+(DATA_WIDTH+1+PE)·P, PE=latched PAR_EN.
- BUSY=0, TX_OUT=1 at N+1+(DATA_WIDTH+2+PE)·P. Frame length 10·P (11·P with parity) for 8 bits.
- Back-to-back: DATA_VALID held high → next accept on first cycle BUSY=0, next start bit one cycle later; minimum inter-frame idle is 1 cycle.
- P=1: one bit per clock; P=0 behaves identically to P=1.

## Test plan
- Reset: assert RST 3 cycles with DATA_VALID=1 → TX_OUT=1, BUSY=0 throughout; no frame starts until RST released.
- P_DATA=0xA5, PAR_EN=0, P=1 → TX_OUT sequence 0,1,0,1,0,0,1,0,1,1 on cycles N+1..N+10; BUSY high exactly 10 cycles.
- P_DATA=0x03, PAR_EN=1, PAR_TYP=0 then PAR_TYP=1, P=8 → parity bit 0 then 1, each held 8 cycles; frame 88 cycles; BUSY deasserts at N+89.
- Mid-frame disturbance: P=4, accept 0x3C, then pulse DATA_VALID with 0xFF and change prescale to 16 during DATA → line carries 0x3C at 4 cycles/bit only; second request dropped.
- Back-to-back: DATA_VALID held high, P_DATA=0x55 then 0x0F, P=2 → two complete frames separated by exactly one idle-high cycle.
- Reset mid-frame: P=8, RST during data bit 3 → next edge TX_OUT=1, BUSY=0; subsequent DATA_VALID sends a clean full frame.
